// File: rtl/fetch_pc_gen.sv
// Fetch-PC generator: one PC per fetch lane, partial-accept advance,
// prioritised redirects (commit > ex > dec), redirect epoch and a halt
// state entered on a misaligned redirect target.

// Per-lane PC and valid, purely combinational from the group base.
module fetch_pc_lane #(
    parameter int XLEN          = 32,
    parameter int FETCH_WIDTH   = 2,
    parameter int ALIGNED_GROUP = 0,
    parameter int LANE          = 0
) (
    input  logic [XLEN-1:0] base,
    input  logic            run,
    output logic [XLEN-1:0] pc,
    output logic            valid
);
    localparam int              LOG_FW   = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 0;
    // Byte mask of the aligned fetch block (power-of-two lanes * 4 bytes).
    localparam logic [XLEN-1:0] BLK_MASK = XLEN'((1 << (LOG_FW + 2)) - 1);
    localparam logic [XLEN-1:0] LANE_OFF = XLEN'(LANE * 4);

    generate
        if (ALIGNED_GROUP != 0) begin : g_aligned
            logic [XLEN-1:0] base_off;

            // Lanes below the base slot inside the block are not fetchable.
            always_comb begin
                base_off       = base & BLK_MASK;
                base_off[1:0]  = 2'b00;
                pc             = (base & ~BLK_MASK) | LANE_OFF;
                valid          = run && (base_off <= LANE_OFF);
            end
        end else begin : g_linear
            // Sequential lanes starting at base, all valid while running.
            always_comb begin
                pc    = base + LANE_OFF;
                valid = run;
            end
        end
    endgenerate
endmodule

module fetch_pc_gen #(
    parameter int              XLEN          = 32,
    parameter int              FETCH_WIDTH   = 2,
    parameter logic [XLEN-1:0] RESET_PC      = 32'h0001_0000,
    parameter int              ALIGNED_GROUP = 0,
    parameter int              EPOCH_W       = 3,
    parameter int              CNT_W         = $clog2(FETCH_WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redir_commit_valid,
    input  logic [XLEN-1:0]             redir_commit_pc,
    input  logic                        redir_ex_valid,
    input  logic [XLEN-1:0]             redir_ex_pc,
    input  logic                        redir_dec_valid,
    input  logic [XLEN-1:0]             redir_dec_pc,
    input  logic [CNT_W-1:0]            accept_cnt,
    output logic [FETCH_WIDTH*XLEN-1:0] fetch_pc,
    output logic [FETCH_WIDTH-1:0]      fetch_valid,
    output logic [EPOCH_W-1:0]          epoch,
    output logic                        misalign_err,
    output logic [XLEN-1:0]             misalign_pc
);
    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
    } redir_t;

    state_t                            state, state_nx;
    logic [XLEN-1:0]                   base, base_nx;
    logic [EPOCH_W-1:0]                epoch_nx;
    logic [XLEN-1:0]                   mpc_nx;
    logic [FETCH_WIDTH-1:0][XLEN-1:0]  lane_pc;
    logic [CNT_W-1:0]                  vld_cnt;
    logic [CNT_W-1:0]                  adv;
    redir_t                            win;

    generate
        for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
            fetch_pc_lane #(
                .XLEN          (XLEN),
                .FETCH_WIDTH   (FETCH_WIDTH),
                .ALIGNED_GROUP (ALIGNED_GROUP),
                .LANE          (i)
            ) u_lane (
                .base  (base),
                .run   (state == RUN),
                .pc    (lane_pc[i]),
                .valid (fetch_valid[i])
            );
        end
    endgenerate

    assign fetch_pc     = lane_pc;
    assign misalign_err = (state == HALT);

    // Count valid lanes and clamp the downstream accept to that count.
    always_comb begin
        vld_cnt = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            vld_cnt = vld_cnt + CNT_W'(fetch_valid[i]);
        end
        adv = (accept_cnt > vld_cnt) ? vld_cnt : accept_cnt;
    end

    // Pick the single winning redirect; in HALT only commit can wake us.
    always_comb begin
        win = '0;
        if (redir_commit_valid) begin
            win.valid = 1'b1;
            win.pc    = redir_commit_pc;
        end else if (state == RUN && redir_ex_valid) begin
            win.valid = 1'b1;
            win.pc    = redir_ex_pc;
        end else if (state == RUN && redir_dec_valid) begin
            win.valid = 1'b1;
            win.pc    = redir_dec_pc;
        end
    end

    // Next-state: redirect beats advance; misaligned targets park in HALT.
    always_comb begin
        state_nx = state;
        base_nx  = base;
        epoch_nx = epoch;
        mpc_nx   = misalign_pc;
        if (win.valid) begin
            epoch_nx = epoch + 1'b1;
            if (win.pc[1:0] == 2'b00) begin
                base_nx  = win.pc;
                state_nx = RUN;
            end else begin
                mpc_nx   = win.pc;
                state_nx = HALT;
            end
        end else if (state == RUN) begin
            base_nx = base + (XLEN'(adv) << 2);
        end
    end

    // State registers, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            base        <= RESET_PC;
            epoch       <= '0;
            misalign_pc <= '0;
        end else begin
            state       <= state_nx;
            base        <= base_nx;
            epoch       <= epoch_nx;
            misalign_pc <= mpc_nx;
        end
    end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: two instances (2-lane linear, 4-lane aligned),
// an arithmetic reference model, a per-cycle compare and literal pins.
module tb_fetch_pc_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cv[2], ev[2], dv[2];
    logic [31:0] cp[2], ep[2], dp[2];
    int          acc[2];
    logic [1:0]  acc0;
    logic [2:0]  acc1;
    assign acc0 = acc[0][1:0];
    assign acc1 = acc[1][2:0];

    logic [63:0]  fp0;
    logic [1:0]   fv0;
    logic [2:0]   eo0;
    logic         me0;
    logic [31:0]  mp0;
    logic [127:0] fp1;
    logic [3:0]   fv1;
    logic [2:0]   eo1;
    logic         me1;
    logic [31:0]  mp1;

    fetch_pc_gen #(.XLEN(32), .FETCH_WIDTH(2), .RESET_PC(32'h0001_0000),
                   .ALIGNED_GROUP(0), .EPOCH_W(3)) dut0 (
        .clk(clk), .rst(rst),
        .redir_commit_valid(cv[0]), .redir_commit_pc(cp[0]),
        .redir_ex_valid(ev[0]), .redir_ex_pc(ep[0]),
        .redir_dec_valid(dv[0]), .redir_dec_pc(dp[0]),
        .accept_cnt(acc0), .fetch_pc(fp0), .fetch_valid(fv0),
        .epoch(eo0), .misalign_err(me0), .misalign_pc(mp0));

    fetch_pc_gen #(.XLEN(32), .FETCH_WIDTH(4), .RESET_PC(32'h0001_0000),
                   .ALIGNED_GROUP(1), .EPOCH_W(3)) dut1 (
        .clk(clk), .rst(rst),
        .redir_commit_valid(cv[1]), .redir_commit_pc(cp[1]),
        .redir_ex_valid(ev[1]), .redir_ex_pc(ep[1]),
        .redir_dec_valid(dv[1]), .redir_dec_pc(dp[1]),
        .accept_cnt(acc1), .fetch_pc(fp1), .fetch_valid(fv1),
        .epoch(eo1), .misalign_err(me1), .misalign_pc(mp1));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_base[2];
    logic [31:0] m_mpc[2];
    int          m_ep[2];
    bit          m_halt[2];

    function automatic int fw_of(int d); return (d == 0) ? 2 : 4; endfunction

    function automatic int moff(int d);
        logic [31:0] r;
        r = m_base[d] % 32'(fw_of(d) * 4);
        return int'(r >> 2);
    endfunction

    function automatic int vcnt(int d);
        if (m_halt[d]) return 0;
        if (d == 0) return fw_of(d);
        return fw_of(d) - moff(d);
    endfunction

    function automatic logic [31:0] exp_pc(int d, int i);
        if (d == 0) return m_base[d] + 32'(4 * i);
        return m_base[d] - (m_base[d] % 32'(fw_of(d) * 4)) + 32'(4 * i);
    endfunction

    function automatic logic exp_v(int d, int i);
        return !m_halt[d] && (d == 0 || i >= moff(d));
    endfunction

    function automatic logic [31:0] dpc(int d, int i);
        return (d == 0) ? fp0[i*32 +: 32] : fp1[i*32 +: 32];
    endfunction

    function automatic logic dvl(int d, int i);
        return (d == 0) ? fv0[i] : fv1[i];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_base[d] = 32'h0001_0000;
            m_mpc[d]  = 32'h0;
            m_ep[d]   = 0;
            m_halt[d] = 1'b0;
        end
    endtask

    task automatic model_step(input int d);
        logic [31:0] t;
        bit          have;
        int          a;
        have = 1'b1;
        t    = 32'h0;
        if (cv[d]) t = cp[d];
        else if (!m_halt[d] && ev[d]) t = ep[d];
        else if (!m_halt[d] && dv[d]) t = dp[d];
        else have = 1'b0;
        if (have) begin
            m_ep[d] = (m_ep[d] + 1) % 8;
            if (t[1:0] == 2'b00) begin
                m_base[d] = t;
                m_halt[d] = 1'b0;
            end else begin
                m_mpc[d]  = t;
                m_halt[d] = 1'b1;
            end
        end else if (!m_halt[d]) begin
            a = (acc[d] < vcnt(d)) ? acc[d] : vcnt(d);
            m_base[d] = m_base[d] + 32'(4 * a);
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            cv[d] = 1'b0; ev[d] = 1'b0; dv[d] = 1'b0;
            cp[d] = 32'h0; ep[d] = 32'h0; dp[d] = 32'h0;
            acc[d] = 0;
        end
    endtask

    // One clock: model follows the same edge the DUT registers on.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else for (int d = 0; d < 2; d++) model_step(d);
        #1;
        idle();
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < fw_of(d); i++) begin
                chk($sformatf("d%0d pc%0d", d, i), dpc(d, i), exp_pc(d, i));
                chk($sformatf("d%0d valid%0d", d, i), 32'(dvl(d, i)), 32'(exp_v(d, i)));
            end
            chk($sformatf("d%0d epoch", d), 32'((d == 0) ? eo0 : eo1), 32'(m_ep[d]));
            chk($sformatf("d%0d err", d), 32'((d == 0) ? me0 : me1), 32'(m_halt[d]));
            chk($sformatf("d%0d mpc", d), (d == 0) ? mp0 : mp1, m_mpc[d]);
        end
    end

    initial begin
        idle();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset values
        chk("rst lane0", dpc(0, 0), 32'h0001_0000);
        chk("rst lane1", dpc(0, 1), 32'h0001_0004);
        chk("rst epoch", 32'(eo0), 32'h0);
        chk("rst err", 32'(me0), 32'h0);
        chk("rst mpc", mp0, 32'h0);
        chk("rst d1 valid", 32'(fv1), 32'hF);

        // full accepts
        acc[0] = 2; step();
        chk("acc2 a lane0", dpc(0, 0), 32'h0001_0008);
        chk("acc2 a lane1", dpc(0, 1), 32'h0001_000C);
        acc[0] = 2; step();
        chk("acc2 b lane0", dpc(0, 0), 32'h0001_0010);
        chk("acc2 b lane1", dpc(0, 1), 32'h0001_0014);

        // asynchronous reset pulse mid-stream
        rst = 1'b1;
        model_reset();
        #1;
        chk("async rst lane0", dpc(0, 0), 32'h0001_0000);
        chk("async rst d1 lane0", dpc(1, 0), 32'h0001_0000);
        #1 rst = 1'b0;

        // partial accepts and clamp
        acc[0] = 1; step(); chk("acc1", dpc(0, 0), 32'h0001_0004);
        acc[0] = 0; step(); chk("acc0", dpc(0, 0), 32'h0001_0004);
        acc[0] = 2; step(); chk("acc2", dpc(0, 0), 32'h0001_000C);
        acc[0] = 3; step(); chk("acc3 clamp", dpc(0, 0), 32'h0001_0014);

        // simultaneous redirects: commit wins, accept ignored
        cv[0] = 1; cp[0] = 32'h200; ev[0] = 1; ep[0] = 32'h300;
        dv[0] = 1; dp[0] = 32'h400; acc[0] = 2; step();
        chk("prio base", dpc(0, 0), 32'h200);
        chk("prio epoch", 32'(eo0), 32'h1);

        // misaligned ex redirect -> HALT
        ev[0] = 1; ep[0] = 32'h202; step();
        chk("halt err", 32'(me0), 32'h1);
        chk("halt mpc", mp0, 32'h202);
        chk("halt valid", 32'(fv0), 32'h0);
        chk("halt epoch", 32'(eo0), 32'h2);
        ev[0] = 1; ep[0] = 32'h500; dv[0] = 1; dp[0] = 32'h600; acc[0] = 2; step();
        chk("halt ignore base", dpc(0, 0), 32'h200);
        chk("halt ignore epoch", 32'(eo0), 32'h2);
        cv[0] = 1; cp[0] = 32'h100; step();
        chk("wake base", dpc(0, 0), 32'h100);
        chk("wake epoch", 32'(eo0), 32'h3);
        chk("wake valid", 32'(fv0), 32'h3);

        // misaligned commit while halted stays halted
        ev[0] = 1; ep[0] = 32'h3; step();
        cv[0] = 1; cp[0] = 32'h101; step();
        chk("halt recommit mpc", mp0, 32'h101);
        chk("halt recommit epoch", 32'(eo0), 32'h5);
        cv[0] = 1; cp[0] = 32'h104; step();
        chk("rewake base", dpc(0, 0), 32'h104);

        // ex over dec
        ev[0] = 1; ep[0] = 32'h40; dv[0] = 1; dp[0] = 32'h80; step();
        chk("ex over dec", dpc(0, 0), 32'h40);
        chk("epoch 7", 32'(eo0), 32'h7);

        // address wrap
        cv[0] = 1; cp[0] = 32'hFFFF_FFFC; step();
        chk("wrap epoch", 32'(eo0), 32'h0);
        chk("wrap lane0", dpc(0, 0), 32'hFFFF_FFFC);
        chk("wrap lane1", dpc(0, 1), 32'h0);
        acc[0] = 2; step();
        chk("wrap next", dpc(0, 0), 32'h4);

        // eight redirects wrap the epoch
        for (int k = 0; k < 8; k++) begin
            dv[0] = 1; dp[0] = 32'h1000 + 32'(16 * k); step();
        end
        chk("epoch wrap", 32'(eo0), 32'h0);
        chk("epoch wrap base", dpc(0, 0), 32'h1070);

        // aligned 4-lane group
        ev[1] = 1; ep[1] = 32'h1008; step();
        chk("ag valid", 32'(fv1), 32'hC);
        chk("ag lane0", dpc(1, 0), 32'h1000);
        chk("ag lane3", dpc(1, 3), 32'h100C);
        acc[1] = 2; step();
        chk("ag adv lane0", dpc(1, 0), 32'h1010);
        chk("ag adv valid", 32'(fv1), 32'hF);
        ev[1] = 1; ep[1] = 32'h100C; step();
        chk("ag one valid", 32'(fv1), 32'h8);
        acc[1] = 4; step();
        chk("ag clamp lane0", dpc(1, 0), 32'h1010);
        chk("ag clamp valid", 32'(fv1), 32'hF);

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Parametrised fetch-PC generator for the front end. It replaces the fixed two-slot next-PC register with an N-lane fetch group, a partial-accept advance, and three prioritised redirect sources (commit, execute, decode). It adds a redirect epoch counter and a halt state for misaligned targets. It sits between the instruction-fetch stage and the instruction memory/decoder, and drives one PC per fetch lane every cycle.

## Interface
Parameters:
- XLEN, 32, PC width.
- FETCH_WIDTH, 2, lanes per fetch group (1..4).
- RESET_PC, 32'h0001_0000, base PC after reset.
- ALIGNED_GROUP, 0. 0: lanes are base+4i. 1: group is the aligned FETCH_WIDTH*4-byte block holding base.
- EPOCH_W, 3, epoch counter width.
- Derived: CNT_W = $clog2(FETCH_WIDTH+1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- redir_commit_valid  in  1  commit/exception redirect; highest priority.
- redir_commit_pc  in  XLEN  commit target.
- redir_ex_valid  in  1  execute branch/jalr mispredict redirect.
- redir_ex_pc  in  XLEN  execute target.
- redir_dec_valid  in  1  decode jal redirect; lowest priority.
- redir_dec_pc  in  XLEN  decode target.
- accept_cnt  in  CNT_W  valid lanes consumed downstream this cycle, counted from the lowest valid lane; 0 = stall.
- fetch_pc  out  FETCH_WIDTH*XLEN  lane i at bits [i*XLEN +: XLEN].
- fetch_valid  out  FETCH_WIDTH  per-lane valid.
- epoch  out  EPOCH_W  current redirect epoch.
- misalign_err  out  1  high while in HALT.
- misalign_pc  out  XLEN  faulting target.

## Operation
- State: base (XLEN), fsm {RUN, HALT}, epoch, misalign_pc. fetch_pc and fetch_valid are combinational from these registers only.
- Reset values: base=RESET_PC, fsm=RUN, epoch=0, misalign_pc=0, misalign_err=0.
- Lanes, ALIGNED_GROUP=0: fetch_pc[i]=base+4i; all lanes valid in RUN.
- Lanes, ALIGNED_GROUP=1: f=base[1+$clog2(FETCH_WIDTH):2] (0 when FETCH_WIDTH=1). fetch_pc[i]={base block, i, 2'b00}. Lanes i>=f are valid and lanes i<f are invalid.
- In HALT, fetch_valid is all zero.
- Winning redirect in RUN: commit over ex over dec. Only the winning source is used; lower-priority sources in the same cycle are dropped.
- Redirect applied (RUN):
  - epoch+=1 (wraps), and accept_cnt is ignored that cycle.
  - If target[1:0]==0: base=target.
  - Otherwise: fsm=HALT, misalign_pc=target, and base is unchanged.
- No redirect in RUN: base+=4*min(accept_cnt, valid lane count). Arithmetic is modulo 2^XLEN and wraps from 0xFFFF_FFFC to 0.
- HALT:
  - ex/dec redirects and accept_cnt are ignored.
  - redir_commit_valid with an aligned target: base=target, fsm=RUN, epoch+=1.
  - redir_commit_valid with a misaligned target: stay in HALT, misalign_pc=target, epoch+=1.
- Downstream must discard instructions tagged with an epoch other than the current epoch.

## Timing
- Redirect at edge t: fetch_pc reflects the target from t+1, and epoch is incremented at t+1.
- Accept at edge t: the advanced group is visible at t+1.
- Zero-latency outputs: a change in base is visible in the same cycle it is registered.
- accept_cnt greater than the valid lane count is clamped and does not cause an error.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronous). The first group after release is at RESET_PC.
- Simultaneous commit + ex + dec redirects: only commit takes effect and epoch increments by exactly 1.

## Test plan
- Reset, FETCH_WIDTH=2, ALIGNED_GROUP=0, accept_cnt=2 for 3 cycles -> groups {0x10000,0x10004}, {0x10008,0x1000C}, {0x10010,0x10014}; epoch=0.
- Partial accept, accept_cnt=1 then 0 then 2 from base 0x10000 -> base 0x10004, 0x10004, 0x1000C; accept_cnt=3 clamps to +8.
- Same-cycle redir_commit_pc=0x200, redir_ex_pc=0x300, redir_dec_pc=0x400, accept_cnt=2 -> next base 0x200, epoch 0->1.
- redir_ex_pc=0x202 -> HALT, misalign_err=1, misalign_pc=0x202, fetch_valid=0. A later ex redirect is ignored. redir_commit_pc=0x100 -> RUN at 0x100, epoch +2 in total.
- ALIGNED_GROUP=1, FETCH_WIDTH=4, redirect to 0x1008 -> valid=4'b1100, pcs {0x1000..0x100C}; accept_cnt=2 -> base 0x1010, valid=4'b1111.
- Wrap checks:
  - Base 0xFFFF_FFFC, accept_cnt=2 -> lanes {0xFFFF_FFFC, 0x0}; next base 0x4.
  - 8 redirects -> epoch wraps back to 0.
  - rst pulse mid-stream -> base=0x10000 immediately.
